// File: rtl/store_monitor.sv
// Store monitor: logs processor stores into an FWFT FIFO and
// tracks program completion (PASS) or watchdog expiry (FAIL).
module store_monitor #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] PASS_ADR  = 32'd100,
    parameter logic [31:0] PASS_DATA = 32'd7,
    parameter int          TIMEOUT   = 1000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     MemWrite,
    input  logic [31:0]              Adr,
    input  logic [31:0]              WriteData,
    input  logic                     rd_en,
    output logic [31:0]              rd_adr,
    output logic [31:0]              rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               drops,
    output logic                     done,
    output logic                     pass,
    output logic [31:0]              cycles
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_RUN,
        S_PASS,
        S_FAIL
    } state_t;

    state_t        state;
    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          push;
    logic          pop;
    logic          match;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign pop   = rd_en && !empty;
    // A full FIFO still accepts a store when the head leaves on the same edge
    assign push  = MemWrite && (!full || pop);
    assign match = MemWrite && (Adr == PASS_ADR) && (WriteData == PASS_DATA);

    assign rd_adr  = empty ? 32'd0 : mem[rptr][63:32];
    assign rd_data = empty ? 32'd0 : mem[rptr][31:0];

    assign done = (state != S_RUN);
    assign pass = (state == S_PASS);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= {Adr, WriteData};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            drops <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (MemWrite && !push && drops != 8'hFF) begin
                drops <= drops + 8'd1;
            end
        end
    end

    // Completion store beats the watchdog; cycles freezes on the FAIL edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_RUN;
            cycles <= '0;
        end else begin
            unique case (state)
                S_RUN: begin
                    if (match) begin
                        state  <= S_PASS;
                        cycles <= cycles + 32'd1;
                    end else if (cycles == 32'(TIMEOUT - 1)) begin
                        state <= S_FAIL;
                    end else begin
                        cycles <= cycles + 32'd1;
                    end
                end
                default: state <= state;
            endcase
        end
    end

endmodule

// File: tb/tb_store_monitor.sv
// Directed bench for store_monitor: FIFO ordering, overflow,
// simultaneous push/pop, PASS detection, watchdog and async reset.
module tb_store_monitor;

    localparam int TO = 40;

    logic        clk = 0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] Adr;
    logic [31:0] WriteData;
    logic        rd_en;
    logic [31:0] rd_adr;
    logic [31:0] rd_data;
    logic        empty;
    logic        full;
    logic [3:0]  count;
    logic [7:0]  drops;
    logic        done;
    logic        pass;
    logic [31:0] cycles;

    int checks = 0;
    int errors = 0;

    store_monitor #(
        .DEPTH(8),
        .PASS_ADR(32'd100),
        .PASS_DATA(32'd7),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .MemWrite(MemWrite),
        .Adr(Adr),
        .WriteData(WriteData),
        .rd_en(rd_en),
        .rd_adr(rd_adr),
        .rd_data(rd_data),
        .empty(empty),
        .full(full),
        .count(count),
        .drops(drops),
        .done(done),
        .pass(pass),
        .cycles(cycles)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        MemWrite  = 0;
        rd_en     = 0;
        Adr       = 0;
        WriteData = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1;
        Adr       = a;
        WriteData = d;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        #2;
        checks++;
        if (empty !== 1 || full !== 0 || count !== 0 || done !== 0 ||
            pass !== 0 || rd_adr !== 0 || rd_data !== 0 ||
            drops !== 0 || cycles !== 0) begin
            errors++;
            $display("FAIL reset_state: empty=%b full=%b count=%0d done=%b pass=%b rd=%h/%h drops=%0d cycles=%0d, want 1 0 0 0 0 0/0 0 0",
                     empty, full, count, done, pass, rd_adr, rd_data, drops, cycles);
        end
        tick();
        reset = 0;
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            store(32'h10 + 32'(4 * i), 32'(i + 1));
            checks++;
            if (count !== 4'(i + 1) || rd_adr !== 32'h10 || rd_data !== 1) begin
                errors++;
                $display("FAIL basic_push%0d: count=%0d head=%h/%h, want %0d 10/1",
                         i, count, rd_adr, rd_data, i + 1);
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd_adr !== 32'h10 + 32'(4 * i) || rd_data !== 32'(i + 1)) begin
                errors++;
                $display("FAIL basic_head%0d: got %h/%h, want %h/%h",
                         i, rd_adr, rd_data, 32'h10 + 32'(4 * i), i + 1);
            end
            rd_en = 1;
            tick();
            rd_en = 0;
            checks++;
            if (count !== 4'(2 - i)) begin
                errors++;
                $display("FAIL basic_pop%0d: count=%0d, want %0d", i, count, 2 - i);
            end
        end
        checks++;
        if (empty !== 1 || drops !== 0 || rd_adr !== 0 || rd_data !== 0) begin
            errors++;
            $display("FAIL basic_end: empty=%b drops=%0d rd=%h/%h, want 1 0 0/0",
                     empty, drops, rd_adr, rd_data);
        end
        // rd_en on an empty FIFO must not cancel the simultaneous push
        rd_en = 1;
        store(32'h40, 32'h55);
        checks++;
        if (count !== 1 || rd_adr !== 32'h40 || rd_data !== 32'h55) begin
            errors++;
            $display("FAIL empty_push_pop: count=%0d head=%h/%h, want 1 40/55",
                     count, rd_adr, rd_data);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            store(32'h100 + 32'(4 * i), 32'(i));
            if (i == 6 || i == 7) begin
                checks++;
                if (full !== (i == 7) || count !== 4'(i + 1)) begin
                    errors++;
                    $display("FAIL overflow_full%0d: full=%b count=%0d, want %b %0d",
                             i, full, count, i == 7, i + 1);
                end
            end
        end
        checks++;
        if (drops !== 2 || count !== 8) begin
            errors++;
            $display("FAIL overflow_drops: drops=%0d count=%0d, want 2 8", drops, count);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rd_adr !== 32'h100 + 32'(4 * i) || rd_data !== 32'(i)) begin
                errors++;
                $display("FAIL overflow_pop%0d: got %h/%h, want %h/%h",
                         i, rd_adr, rd_data, 32'h100 + 32'(4 * i), i);
            end
            rd_en = 1;
            tick();
            rd_en = 0;
        end
        checks++;
        if (empty !== 1 || drops !== 2) begin
            errors++;
            $display("FAIL overflow_end: empty=%b drops=%0d, want 1 2", empty, drops);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            store(32'h200 + 32'(i), 32'(i + 16));
        end
        store(32'h2FF, 32'hDEAD);
        rd_en = 1;
        store(32'h300, 32'hAA);
        checks++;
        if (count !== 8 || full !== 1 || drops !== 1 ||
            rd_adr !== 32'h201 || rd_data !== 32'd17) begin
            errors++;
            $display("FAIL full_push_pop: count=%0d full=%b drops=%0d head=%h/%h, want 8 1 1 201/11",
                     count, full, drops, rd_adr, rd_data);
        end
        for (int i = 1; i < 9; i++) begin
            rd_en = 1;
            tick();
            rd_en = 0;
        end
        checks++;
        if (empty !== 1) begin
            errors++;
            $display("FAIL b2b_drain: empty=%b, want 1", empty);
        end
        do_reset();
        for (int i = 0; i < 8; i++) begin
            store(32'h200 + 32'(i), 32'(i + 16));
        end
        rd_en = 1;
        store(32'h300, 32'hAA);
        for (int i = 1; i < 8; i++) begin
            rd_en = 1;
            tick();
            rd_en = 0;
        end
        checks++;
        if (count !== 1 || rd_adr !== 32'h300 || rd_data !== 32'hAA) begin
            errors++;
            $display("FAIL b2b_tail: count=%0d head=%h/%h, want 1 300/aa",
                     count, rd_adr, rd_data);
        end
    endtask

    task automatic test_pass();
        do_reset();
        for (int i = 0; i < 20; i++) tick();
        store(32'd100, 32'd5);
        checks++;
        if (pass !== 0 || done !== 0 || cycles !== 21) begin
            errors++;
            $display("FAIL pass_wrong_data: pass=%b done=%b cycles=%0d, want 0 0 21",
                     pass, done, cycles);
        end
        for (int i = 21; i < 30; i++) tick();
        store(32'd100, 32'd7);
        checks++;
        if (pass !== 1 || done !== 1 || cycles !== 31) begin
            errors++;
            $display("FAIL pass_match: pass=%b done=%b cycles=%0d, want 1 1 31",
                     pass, done, cycles);
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (pass !== 1 || cycles !== 31 || count !== 2 ||
            rd_adr !== 32'd100 || rd_data !== 32'd5) begin
            errors++;
            $display("FAIL pass_frozen: pass=%b cycles=%0d count=%0d head=%h/%h, want 1 31 2 64/5",
                     pass, cycles, count, rd_adr, rd_data);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < TO - 1; i++) tick();
        checks++;
        if (done !== 0 || cycles !== TO - 1) begin
            errors++;
            $display("FAIL timeout_before: done=%b cycles=%0d, want 0 %0d",
                     done, cycles, TO - 1);
        end
        tick();
        checks++;
        if (done !== 1 || pass !== 0 || cycles !== TO - 1) begin
            errors++;
            $display("FAIL timeout_fire: done=%b pass=%b cycles=%0d, want 1 0 %0d",
                     done, pass, cycles, TO - 1);
        end
        store(32'd100, 32'd7);
        tick();
        checks++;
        if (pass !== 0 || done !== 1 || cycles !== TO - 1 || count !== 1) begin
            errors++;
            $display("FAIL timeout_sticky: pass=%b done=%b cycles=%0d count=%0d, want 0 1 %0d 1",
                     pass, done, cycles, count, TO - 1);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        store(32'h10, 32'd1);
        store(32'h14, 32'd2);
        store(32'h18, 32'd3);
        store(32'd100, 32'd7);
        checks++;
        if (count !== 4 || pass !== 1) begin
            errors++;
            $display("FAIL areset_setup: count=%0d pass=%b, want 4 1", count, pass);
        end
        #2;
        reset = 1;
        #1;
        checks++;
        if (empty !== 1 || count !== 0 || pass !== 0 || done !== 0 ||
            rd_adr !== 0 || rd_data !== 0 || cycles !== 0 || drops !== 0) begin
            errors++;
            $display("FAIL areset_now: empty=%b count=%0d pass=%b done=%b rd=%h/%h cycles=%0d drops=%0d",
                     empty, count, pass, done, rd_adr, rd_data, cycles, drops);
        end
        tick();
        reset = 0;
        tick();
        checks++;
        if (done !== 0 || count !== 0 || cycles !== 1) begin
            errors++;
            $display("FAIL areset_release: done=%b count=%0d cycles=%0d, want 0 0 1",
                     done, count, cycles);
        end
    endtask

    initial begin
        idle();
        reset = 1;
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_pass();
        test_timeout();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
